// File: rtl/seq_shift_unit.sv
// Bit-serial 32-bit shift/rotate unit: one bit position per clock, registered result.
// Busy from accept until done; starts arriving while busy are dropped, not queued.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   res
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step;
  logic               last_step;

  always_comb begin
    step = {work[0], work[WIDTH-1:1]};
    case (op_q)
      OP_SLL:  step = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: step = {work[0], work[WIDTH-1:1]};
    endcase
  end

  assign last_step = (cnt == SHAMT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // done and res are loaded on the edge entering FINISH so both are visible in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      cnt   <= '0;
      work  <= '0;
      res   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            work <= in1;
            cnt  <= shamt;
            if (shamt == '0) begin
              res  <= in1;
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - SHAMT_W'(1);
          if (last_step) begin
            res  <= step;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
